corr_window_engine: RTL and testbench

Computes the match score between a stored template and the window of the saved frame anchored at a given (X, Y) coordinate. It sits directly upstream of the correlation sweep controller:
- it takes the controller's current X/Y;
- it reads frame and template pixels from their on-chip RAMs;
- it returns one 32-bit score with a one-cycle finished pulse per window.

The controller keeps the maximum score and advances the coordinate.

---
 rtl/corr_window_engine.sv | 155 +++++++++++++++
 tb/tb_corr_window_engine.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/corr_window_engine.sv
// Template/frame window correlator: streams one pixel pair per cycle, returns a 32-bit score per window.
// Optional build macro CORR_SAD_EN switches the score from sum of products to inverted sum of absolute differences.
module corr_window_engine #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int TPL_W   = 16,
    parameter int TPL_H   = 16,
    parameter int PIX_W   = 8,
    parameter int FADDR_W = 19,
    parameter int TADDR_W = 8
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iStart,
    input  logic [12:0]        iX,
    input  logic [12:0]        iY,
    output logic [FADDR_W-1:0] oFrameAddr,
    input  logic [PIX_W-1:0]   iFramePix,
    output logic [TADDR_W-1:0] oTplAddr,
    input  logic [PIX_W-1:0]   iTplPix,
    output logic [31:0]        oCorr,
    output logic               oCorrFinished,
    output logic               oBusy
);

    localparam int          STAGES    = 2;
    localparam logic [31:0] LAST_ADDR = 32'(H_RES * V_RES - 1);
    localparam logic [31:0] ROW_STEP  = 32'(H_RES - (TPL_W - 1));

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state;
    logic [15:0]       txCnt, tyCnt;
    logic [31:0]       curX, curY, rawAddr;
    logic [1:0]        drainCnt;
    logic [STAGES:0]   vldPipe;
    logic [2*PIX_W-1:0] prod;
    logic [31:0]       acc;

    logic              lastPair, txWrap, nxtIn, vldNext;
    logic [31:0]       nxtX, nxtY, nxtRaw;
    logic [PIX_W-1:0]  absDiff;

    // Next coordinate: the start point while idle, otherwise one incremental step.
    always_comb begin
        txWrap   = (txCnt == 16'(TPL_W - 1));
        lastPair = txWrap && (tyCnt == 16'(TPL_H - 1));
        nxtX     = curX;
        nxtY     = curY;
        nxtRaw   = rawAddr;
        if (state == IDLE) begin
            nxtX   = 32'(iX);
            nxtY   = 32'(iY);
            nxtRaw = 32'(iY) * 32'(H_RES) + 32'(iX);
        end else if (txWrap) begin
            nxtX   = curX - 32'(TPL_W - 1);
            nxtY   = curY + 32'd1;
            nxtRaw = rawAddr + ROW_STEP;
        end else begin
            nxtX   = curX + 32'd1;
            nxtRaw = rawAddr + 32'd1;
        end
        nxtIn   = (nxtX < 32'(H_RES)) && (nxtY < 32'(V_RES));
        vldNext = 1'b0;
        if ((state == IDLE && iStart) || (state == RUN && !lastPair))
            vldNext = nxtIn;
        absDiff = (iFramePix > iTplPix) ? iFramePix - iTplPix : iTplPix - iFramePix;
    end

    // Valid bits follow each pair; an out-of-frame pair contributes nothing.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            vldPipe <= '0;
            prod    <= '0;
            acc     <= '0;
        end else begin
            vldPipe <= {vldPipe[STAGES-1:0], vldNext};
            if (vldPipe[1]) begin
`ifdef CORR_SAD_EN
                prod <= {{PIX_W{1'b0}}, absDiff};
`else
                prod <= iFramePix * iTplPix;
`endif
            end else begin
                prod <= '0;
            end
            if (state == IDLE && iStart)
                acc <= '0;
            else if (vldPipe[2])
                acc <= acc + 32'(prod);
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state         <= IDLE;
            txCnt         <= '0;
            tyCnt         <= '0;
            curX          <= '0;
            curY          <= '0;
            rawAddr       <= '0;
            drainCnt      <= '0;
            oFrameAddr    <= '0;
            oTplAddr      <= '0;
            oCorr         <= '0;
            oCorrFinished <= 1'b0;
        end else begin
            oCorrFinished <= 1'b0;
            case (state)
                IDLE: if (iStart) begin
                    curX       <= nxtX;
                    curY       <= nxtY;
                    rawAddr    <= nxtRaw;
                    txCnt      <= '0;
                    tyCnt      <= '0;
                    oFrameAddr <= FADDR_W'(nxtIn ? nxtRaw : LAST_ADDR);
                    oTplAddr   <= '0;
                    state      <= RUN;
                end
                RUN: if (lastPair) begin
                    drainCnt <= '0;
                    state    <= DRAIN;
                end else begin
                    curX       <= nxtX;
                    curY       <= nxtY;
                    rawAddr    <= nxtRaw;
                    oFrameAddr <= FADDR_W'(nxtIn ? nxtRaw : LAST_ADDR);
                    oTplAddr   <= oTplAddr + TADDR_W'(1);
                    if (txWrap) begin
                        txCnt <= '0;
                        tyCnt <= tyCnt + 16'd1;
                    end else begin
                        txCnt <= txCnt + 16'd1;
                    end
                end
                DRAIN: if (drainCnt == 2'd2) begin
`ifdef CORR_SAD_EN
                    oCorr <= 32'hFFFF_FFFF - acc;
`else
                    oCorr <= acc;
`endif
                    oCorrFinished <= 1'b1;
                    state         <= DONE;
                end else begin
                    drainCnt <= drainCnt + 2'd1;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign oBusy = (state != IDLE);

endmodule

// File: tb/tb_corr_window_engine.sv
// Directed bench for corr_window_engine on an 8x8 frame with a 2x2 template.
module tb_corr_window_engine;

    localparam int H_RES = 8, V_RES = 8, TPL_W = 2, TPL_H = 2, PIX_W = 8;
    localparam int FADDR_W = 19, TADDR_W = 8;

    logic               iCLK = 1'b0;
    logic               iRST, iStart;
    logic [12:0]        iX, iY;
    logic [FADDR_W-1:0] oFrameAddr;
    logic [PIX_W-1:0]   iFramePix, iTplPix;
    logic [TADDR_W-1:0] oTplAddr;
    logic [31:0]        oCorr;
    logic               oCorrFinished, oBusy;

    logic [PIX_W-1:0]   frameMem [0:63];
    logic [PIX_W-1:0]   tplMem   [0:3];
    logic [31:0]        capAddr  [0:3];
    int                 nChecks = 0, nPass = 0;

    corr_window_engine #(
        .H_RES(H_RES), .V_RES(V_RES), .TPL_W(TPL_W), .TPL_H(TPL_H),
        .PIX_W(PIX_W), .FADDR_W(FADDR_W), .TADDR_W(TADDR_W)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iX(iX), .iY(iY),
        .oFrameAddr(oFrameAddr), .iFramePix(iFramePix),
        .oTplAddr(oTplAddr), .iTplPix(iTplPix),
        .oCorr(oCorr), .oCorrFinished(oCorrFinished), .oBusy(oBusy)
    );

    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) begin
        iFramePix <= frameMem[oFrameAddr[5:0]];
        iTplPix   <= tplMem[oTplAddr[1:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else nPass++;
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    // Called just after an edge (cycle 0); returns at cycle 8 (the pulse cycle).
    task automatic runWin(input int x, input int y, input logic [31:0] expCorr,
                          input logic [31:0] heldCorr, input int injectCyc, input string tag);
        iX = 13'(x); iY = 13'(y); iStart = 1'b1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            tick();
            iStart = (cyc == injectCyc);
            if (cyc == injectCyc) begin iX = '0; iY = '0; end
            check($sformatf("%s_busy%0d", tag, cyc), 32'(oBusy), 32'd1);
            check($sformatf("%s_fin%0d", tag, cyc), 32'(oCorrFinished), 32'(cyc == 8));
            if (cyc < 8) check($sformatf("%s_held%0d", tag, cyc), oCorr, heldCorr);
            else         check($sformatf("%s_corr", tag), oCorr, expCorr);
            if (cyc <= 4) begin
                capAddr[cyc-1] = 32'(oFrameAddr);
                check($sformatf("%s_taddr%0d", tag, cyc), 32'(oTplAddr), 32'(cyc - 1));
            end
        end
        iStart = 1'b0;
    endtask

    task automatic idleTick(input string tag);
        tick();
        check({tag, "_idlebusy"}, 32'(oBusy), 32'd0);
        check({tag, "_idlefin"}, 32'(oCorrFinished), 32'd0);
    endtask

    logic [31:0] expA, expB;

    initial begin
        iRST = 1'b1; iStart = 1'b0; iX = '0; iY = '0;
        for (int i = 0; i < 64; i++) frameMem[i] = 8'(i);
        for (int i = 0; i < 4; i++) tplMem[i] = 8'd1;
        tick(); tick();
        check("rst_corr", oCorr, 32'd0);
        check("rst_fin", 32'(oCorrFinished), 32'd0);
        check("rst_busy", 32'(oBusy), 32'd0);
        check("rst_faddr", 32'(oFrameAddr), 32'd0);
        check("rst_taddr", 32'(oTplAddr), 32'd0);
        iRST = 1'b0;
        tick();

        // basic window
        runWin(2, 3, 32'd122, 32'd0, -1, "t1");
        check("t1_a0", capAddr[0], 32'd26);
        check("t1_a1", capAddr[1], 32'd27);
        check("t1_a2", capAddr[2], 32'd34);
        check("t1_a3", capAddr[3], 32'd35);
        idleTick("t1");

        // corner window, three pixels off-frame
        runWin(7, 7, 32'd63, 32'd122, -1, "t2");
        for (int i = 0; i < 4; i++) check($sformatf("t2_a%0d", i), capAddr[i], 32'd63);
        idleTick("t2");

        // start during RUN ignored; next start accepted at cycle 9
        runWin(2, 3, 32'd122, 32'd63, 3, "t3");
        idleTick("t3");
        runWin(0, 0, 32'd18, 32'd122, -1, "t3b");
        idleTick("t3b");

        // reset mid-RUN
        iX = 13'd2; iY = 13'd3; iStart = 1'b1;
        tick();
        iStart = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        iRST = 1'b1;
        tick();
        check("t4_corr", oCorr, 32'd0);
        check("t4_fin", 32'(oCorrFinished), 32'd0);
        check("t4_busy", 32'(oBusy), 32'd0);
        check("t4_faddr", 32'(oFrameAddr), 32'd0);
        check("t4_taddr", 32'(oTplAddr), 32'd0);
        iRST = 1'b0;
        for (int i = 0; i < 5; i++) idleTick($sformatf("t4_%0d", i));
        runWin(2, 3, 32'd122, 32'd0, -1, "t4r");
        idleTick("t4r");

        // back-to-back windows, each started the cycle after the previous pulse
        runWin(0, 0, 32'd18, 32'd122, -1, "t6a");
        idleTick("t6a");
        runWin(1, 0, 32'd22, 32'd18, -1, "t6b");
        idleTick("t6b");

        // flat frame vs flat template
`ifdef CORR_SAD_EN
        expA = 32'hFFFF_FFFF;
        expB = 32'hFFFF_FFD7;
`else
        expA = 32'd160000;
        expB = 32'd152000;
`endif
        for (int i = 0; i < 64; i++) frameMem[i] = 8'd200;
        for (int i = 0; i < 4; i++) tplMem[i] = 8'd200;
        runWin(0, 0, expA, 32'd22, -1, "t5a");
        idleTick("t5a");
        for (int i = 0; i < 4; i++) tplMem[i] = 8'd190;
        runWin(0, 0, expB, expA, -1, "t5b");
        idleTick("t5b");

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
